// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the TX PLL control slice.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PWRUP   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_RATECHG = 3'd4,
        ST_FAIL    = 3'd5
    } pll_seq_state_e;

    localparam logic [7:0]  DIV_DEFAULT = 8'd50;
    localparam int unsigned REF_TGL_PER = 4;
    localparam int unsigned PCLK_DIV    = 20;

    // Expected PCLK cycles per ref_div_tgl level, truncated.
    function automatic logic [7:0] calc_exp(input logic [7:0] div);
        return 8'((32'(div) * REF_TGL_PER) / PCLK_DIV);
    endfunction

endpackage

// File: rtl/pll_freq_meter.sv
// Measures PCLK cycles between ref_div_tgl edges and flags each window as good or bad.
module pll_freq_meter
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned TOL = 1
)(
    input  logic       PCLK,
    input  logic       Rst,
    input  logic       clr,
    input  logic       ref_div_tgl,
    input  logic [7:0] exp_cnt,
    output logic       good,
    output logic       bad
);

    logic [2:0] sync_q;
    logic [8:0] cnt;
    logic [8:0] meas;
    logic [8:0] exp_w;
    logic [8:0] limit;
    logic [8:0] diff;
    logic       boundary;
    logic       win_good;
    logic       win_tmo;

    always_comb begin
        boundary = sync_q[2] ^ sync_q[1];
        meas     = cnt + 9'd1;
        exp_w    = {1'b0, exp_cnt};
        limit    = {exp_cnt, 1'b0};
        diff     = (meas >= exp_w) ? meas - exp_w : exp_w - meas;
        win_good = (diff <= 9'(TOL));
        // No edge by twice the expected length: close the window as bad.
        win_tmo  = !boundary && (meas >= limit);
    end

    always_ff @(posedge PCLK) begin
        if (Rst) begin
            sync_q <= '0;
            cnt    <= '0;
            good   <= 1'b0;
            bad    <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], ref_div_tgl};
            if (clr) begin
                cnt  <= '0;
                good <= 1'b0;
                bad  <= 1'b0;
            end else if (boundary || win_tmo) begin
                cnt  <= '0;
                good <= boundary && win_good;
                bad  <= !(boundary && win_good);
            end else begin
                cnt  <= meas;
                good <= 1'b0;
                bad  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pll_lock_seq.sv
// PLL power-up, lock qualification, rate change and loss-of-lock sequencer for the TX clock path.
module pll_lock_seq
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned TOL         = 1,
    parameter int unsigned SETTLE_CYC  = 64,
    parameter int unsigned LOCK_GOOD   = 4,
    parameter int unsigned LOSS_BAD    = 2,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned MAX_RETRY   = 3
)(
    input  logic       PCLK,
    input  logic       Rst,
    input  logic       enable,
    input  logic       ref_div_tgl,
    input  logic       rate_req,
    input  logic [7:0] rate_div,
    output logic       rate_ack,
    output logic       pll_en,
    output logic [7:0] div_ratio,
    output logic       pll_locked,
    output logic       tx_clk_en,
    output logic       lock_fail,
    output logic [2:0] state_dbg
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GW = $clog2(LOCK_GOOD + 1);
    localparam int unsigned BW = $clog2(LOSS_BAD + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_GOOD - 1);
    localparam logic [BW-1:0] LOSS_LAST   = BW'(LOSS_BAD - 1);
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

    pll_seq_state_e state, state_nx;

    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic [RW-1:0] retry_cnt;
    logic          rate_pend;
    logic [7:0]    new_div;
    logic [7:0]    exp_cnt;
    logic          win_good;
    logic          win_bad;
    logic          meter_clr;
    logic          timeout;
    logic          rate_reject;
    logic          ack_nx;

    assign exp_cnt   = calc_exp(div_ratio);
    assign state_dbg = state;

    pll_freq_meter #(.TOL(TOL)) u_meter (
        .PCLK        (PCLK),
        .Rst         (Rst),
        .clr         (meter_clr),
        .ref_div_tgl (ref_div_tgl),
        .exp_cnt     (exp_cnt),
        .good        (win_good),
        .bad         (win_bad)
    );

    always_comb begin
        state_nx    = state;
        timeout     = 1'b0;
        rate_reject = 1'b0;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (!lock_fail) state_nx = ST_PWRUP;
                ST_PWRUP:   if (settle_cnt == SETTLE_LAST) state_nx = ST_CHECK;
                ST_CHECK: begin
                    if (win_good && good_cnt == GOOD_LAST) begin
                        state_nx = ST_LOCKED;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout  = 1'b1;
                        state_nx = (retry_cnt == RETRY_LAST) ? ST_FAIL : ST_PWRUP;
                    end
                end
                ST_LOCKED: begin
                    // Loss of lock wins over a same-cycle rate request; the ack cycle itself is not a new request.
                    if (win_bad && bad_cnt == LOSS_LAST) begin
                        state_nx = ST_CHECK;
                    end else if (rate_req && !rate_ack) begin
                        if (rate_div == '0) rate_reject = 1'b1;
                        else                state_nx    = ST_RATECHG;
                    end
                end
                ST_RATECHG: state_nx = ST_PWRUP;
                ST_FAIL:    state_nx = ST_FAIL;
                default:    state_nx = ST_IDLE;
            endcase
        end
        ack_nx    = rate_reject ||
                    (rate_pend && (state_nx == ST_LOCKED || state_nx == ST_FAIL || state_nx == ST_IDLE));
        meter_clr = (state_nx == ST_PWRUP && state != ST_PWRUP) || state == ST_IDLE || state == ST_FAIL;
    end

    always_ff @(posedge PCLK) begin
        if (Rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            retry_cnt  <= '0;
            rate_pend  <= 1'b0;
            new_div    <= DIV_DEFAULT;
            div_ratio  <= DIV_DEFAULT;
            pll_en     <= 1'b0;
            pll_locked <= 1'b0;
            tx_clk_en  <= 1'b0;
            lock_fail  <= 1'b0;
            rate_ack   <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= (state == ST_PWRUP && state_nx == ST_PWRUP) ? settle_cnt + 1'b1 : '0;
            tmo_cnt    <= (state == ST_CHECK && state_nx == ST_CHECK) ? tmo_cnt + 1'b1 : '0;

            if (state == ST_CHECK && state_nx == ST_CHECK) begin
                if (win_bad)       good_cnt <= '0;
                else if (win_good) good_cnt <= good_cnt + 1'b1;
            end else begin
                good_cnt <= '0;
            end

            if (state == ST_LOCKED && state_nx == ST_LOCKED) begin
                if (win_bad)       bad_cnt <= bad_cnt + 1'b1;
                else if (win_good) bad_cnt <= '0;
            end else begin
                bad_cnt <= '0;
            end

            if (state_nx == ST_LOCKED || state_nx == ST_IDLE) retry_cnt <= '0;
            else if (timeout)                                  retry_cnt <= retry_cnt + 1'b1;

            if (ack_nx)                                             rate_pend <= 1'b0;
            else if (state == ST_LOCKED && state_nx == ST_RATECHG) rate_pend <= 1'b1;

            if (state == ST_LOCKED && state_nx == ST_RATECHG) new_div   <= rate_div;
            if (state == ST_RATECHG && state_nx == ST_PWRUP)  div_ratio <= new_div;

            pll_en     <= (state_nx inside {ST_PWRUP, ST_CHECK, ST_LOCKED, ST_RATECHG});
            pll_locked <= (state_nx == ST_LOCKED || state_nx == ST_RATECHG);
            tx_clk_en  <= (state == ST_LOCKED && state_nx == ST_LOCKED);
            lock_fail  <= (state_nx == ST_FAIL);
            rate_ack   <= ack_nx;
        end
    end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq: lock, loss, rate change, timeout/fail and reset/disable paths.
`timescale 1ns/1ps
module tb_pll_lock_seq;

    logic       PCLK        = 1'b0;
    logic       Rst         = 1'b1;
    logic       enable      = 1'b0;
    logic       ref_div_tgl = 1'b0;
    logic       rate_req    = 1'b0;
    logic [7:0] rate_div    = 8'd0;
    logic       rate_ack;
    logic       pll_en;
    logic [7:0] div_ratio;
    logic       pll_locked;
    logic       tx_clk_en;
    logic       lock_fail;
    logic [2:0] state_dbg;

    int          checks = 0;
    int          errors = 0;
    bit          tgl_run = 1'b1;
    int unsigned tgl_ns  = 40;

    pll_lock_seq dut (
        .PCLK        (PCLK),
        .Rst         (Rst),
        .enable      (enable),
        .ref_div_tgl (ref_div_tgl),
        .rate_req    (rate_req),
        .rate_div    (rate_div),
        .rate_ack    (rate_ack),
        .pll_en      (pll_en),
        .div_ratio   (div_ratio),
        .pll_locked  (pll_locked),
        .tx_clk_en   (tx_clk_en),
        .lock_fail   (lock_fail),
        .state_dbg   (state_dbg)
    );

    always #2 PCLK = ~PCLK;

    // Reference toggle lands 1 ns after a negedge, never on a PCLK edge.
    initial begin
        #1;
        forever begin
            #(tgl_ns);
            if (tgl_run) ref_div_tgl = ~ref_div_tgl;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (state_dbg == st) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; enable = 1'b1; rate_req = 1'b1; rate_div = 8'd7;
        tick(); tick();
        checks++; if (state_dbg !== 3'd0)   begin errors++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
        checks++; if (pll_en !== 1'b0)      begin errors++; $display("FAIL rst_pll_en: got %b want 0", pll_en); end
        checks++; if (div_ratio !== 8'd50)  begin errors++; $display("FAIL rst_div: got %0d want 50", div_ratio); end
        checks++; if (pll_locked !== 1'b0)  begin errors++; $display("FAIL rst_locked: got %b want 0", pll_locked); end
        checks++; if (tx_clk_en !== 1'b0)   begin errors++; $display("FAIL rst_tx_en: got %b want 0", tx_clk_en); end
        checks++; if (lock_fail !== 1'b0)   begin errors++; $display("FAIL rst_lock_fail: got %b want 0", lock_fail); end
        checks++; if (rate_ack !== 1'b0)    begin errors++; $display("FAIL rst_ack: got %b want 0", rate_ack); end
        rate_req = 1'b0; enable = 1'b0;
    endtask

    task automatic test_lock();
        int n;
        Rst = 1'b0; enable = 1'b1;
        tick();
        checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL pwrup_entry: got %0d want 1", state_dbg); end
        checks++; if (pll_en !== 1'b1)    begin errors++; $display("FAIL pwrup_pll_en: got %b want 1", pll_en); end
        wait_state(3'd2, 100, n);
        checks++; if (n != 64) begin errors++; $display("FAIL settle_len: got %0d want 64", n); end
        wait_state(3'd3, 400, n);
        checks++; if (n < 0)               begin errors++; $display("FAIL lock_wait: got timeout want LOCKED"); end
        checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b want 1", pll_locked); end
        checks++; if (tx_clk_en !== 1'b0)  begin errors++; $display("FAIL lock_tx_first: got %b want 0", tx_clk_en); end
        tick();
        checks++; if (tx_clk_en !== 1'b1)  begin errors++; $display("FAIL lock_tx_second: got %b want 1", tx_clk_en); end
    endtask

    task automatic test_loss();
        int n;
        tick(); tick();
        tgl_run = 1'b0;
        wait_state(3'd2, 200, n);
        checks++; if (n < 30 || n > 50)    begin errors++; $display("FAIL loss_time: got %0d want 30..50", n); end
        checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL loss_locked: got %b want 0", pll_locked); end
        checks++; if (tx_clk_en !== 1'b0)  begin errors++; $display("FAIL loss_tx_en: got %b want 0", tx_clk_en); end
        checks++; if (pll_en !== 1'b1)     begin errors++; $display("FAIL loss_pll_en: got %b want 1", pll_en); end
        tgl_run = 1'b1;
        wait_state(3'd3, 400, n);
        checks++; if (n < 0) begin errors++; $display("FAIL relock_wait: got timeout want LOCKED"); end
    endtask

    task automatic test_rate_change();
        int n;
        int acks;
        tick(); tick();
        rate_div = 8'd100; rate_req = 1'b1;
        tick();
        checks++; if (state_dbg !== 3'd4)  begin errors++; $display("FAIL rc_state: got %0d want 4", state_dbg); end
        checks++; if (tx_clk_en !== 1'b0)  begin errors++; $display("FAIL rc_tx_en: got %b want 0", tx_clk_en); end
        checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL rc_locked: got %b want 1", pll_locked); end
        checks++; if (div_ratio !== 8'd50) begin errors++; $display("FAIL rc_div_hold: got %0d want 50", div_ratio); end
        tgl_ns = 80;
        tick();
        checks++; if (state_dbg !== 3'd1)   begin errors++; $display("FAIL rc_pwrup: got %0d want 1", state_dbg); end
        checks++; if (div_ratio !== 8'd100) begin errors++; $display("FAIL rc_div_new: got %0d want 100", div_ratio); end
        checks++; if (pll_locked !== 1'b0)  begin errors++; $display("FAIL rc_unlocked: got %b want 0", pll_locked); end
        acks = 0; n = -1;
        for (int i = 1; i <= 600; i++) begin
            tick();
            if (rate_ack === 1'b1) acks++;
            if (state_dbg == 3'd3) begin
                n = i;
                break;
            end
        end
        checks++; if (n < 0)             begin errors++; $display("FAIL rc_relock: got timeout want LOCKED"); end
        checks++; if (rate_ack !== 1'b1) begin errors++; $display("FAIL rc_ack_at_lock: got %b want 1", rate_ack); end
        rate_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rate_ack === 1'b1) acks++;
        end
        checks++; if (acks != 1)           begin errors++; $display("FAIL rc_ack_count: got %0d want 1", acks); end
        checks++; if (tx_clk_en !== 1'b1)  begin errors++; $display("FAIL rc_tx_back: got %b want 1", tx_clk_en); end
    endtask

    task automatic test_rate_zero();
        rate_div = 8'd0; rate_req = 1'b1;
        tick();
        checks++; if (rate_ack !== 1'b1)    begin errors++; $display("FAIL rz_ack: got %b want 1", rate_ack); end
        checks++; if (state_dbg !== 3'd3)   begin errors++; $display("FAIL rz_state: got %0d want 3", state_dbg); end
        checks++; if (div_ratio !== 8'd100) begin errors++; $display("FAIL rz_div: got %0d want 100", div_ratio); end
        rate_req = 1'b0;
        tick();
        checks++; if (rate_ack !== 1'b0)   begin errors++; $display("FAIL rz_ack_pulse: got %b want 0", rate_ack); end
        checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL rz_locked: got %b want 1", pll_locked); end
        checks++; if (tx_clk_en !== 1'b1)  begin errors++; $display("FAIL rz_tx_en: got %b want 1", tx_clk_en); end
    endtask

    task automatic test_timeout_fail();
        int      n;
        int      pw;
        bit      saw_lock;
        logic [2:0] prev;
        tgl_ns = 52;
        wait_state(3'd2, 300, n);
        checks++; if (n < 0) begin errors++; $display("FAIL tf_loss: got timeout want CHECK"); end
        pw = 0; saw_lock = 1'b0; prev = state_dbg; n = -1;
        for (int i = 1; i <= 4000; i++) begin
            tick();
            if (state_dbg == 3'd1 && prev != 3'd1) pw++;
            if (pll_locked === 1'b1) saw_lock = 1'b1;
            prev = state_dbg;
            if (state_dbg == 3'd5) begin
                n = i;
                break;
            end
        end
        checks++; if (n != 3200)          begin errors++; $display("FAIL tf_fail_time: got %0d want 3200", n); end
        checks++; if (pw != 2)            begin errors++; $display("FAIL tf_retries: got %0d want 2", pw); end
        checks++; if (saw_lock != 1'b0)   begin errors++; $display("FAIL tf_no_lock: got %b want 0", saw_lock); end
        checks++; if (pll_en !== 1'b0)    begin errors++; $display("FAIL tf_pll_en: got %b want 0", pll_en); end
        checks++; if (lock_fail !== 1'b1) begin errors++; $display("FAIL tf_lock_fail: got %b want 1", lock_fail); end
        tick(); tick(); tick();
        checks++; if (state_dbg !== 3'd5) begin errors++; $display("FAIL tf_sticky_state: got %0d want 5", state_dbg); end
        checks++; if (lock_fail !== 1'b1) begin errors++; $display("FAIL tf_sticky_flag: got %b want 1", lock_fail); end
        enable = 1'b0;
        tick();
        checks++; if (state_dbg !== 3'd0)   begin errors++; $display("FAIL tf_idle: got %0d want 0", state_dbg); end
        checks++; if (lock_fail !== 1'b0)   begin errors++; $display("FAIL tf_clear: got %b want 0", lock_fail); end
        checks++; if (div_ratio !== 8'd100) begin errors++; $display("FAIL tf_div_kept: got %0d want 100", div_ratio); end
    endtask

    task automatic test_rst_in_check();
        int n;
        tgl_ns = 40;
        Rst = 1'b1;
        tick();
        Rst = 1'b0; enable = 1'b1;
        wait_state(3'd3, 400, n);
        checks++; if (n < 0)               begin errors++; $display("FAIL rst_relock: got timeout want LOCKED"); end
        checks++; if (div_ratio !== 8'd50) begin errors++; $display("FAIL rst_div_before: got %0d want 50", div_ratio); end
        rate_div = 8'd100; rate_req = 1'b1;
        wait_state(3'd2, 200, n);
        checks++; if (n < 0) begin errors++; $display("FAIL rst_reach_check: got timeout want CHECK"); end
        Rst = 1'b1;
        tick();
        checks++; if (state_dbg !== 3'd0)  begin errors++; $display("FAIL rstc_state: got %0d want 0", state_dbg); end
        checks++; if (div_ratio !== 8'd50) begin errors++; $display("FAIL rstc_div: got %0d want 50", div_ratio); end
        checks++; if (pll_en !== 1'b0)     begin errors++; $display("FAIL rstc_pll_en: got %b want 0", pll_en); end
        checks++; if (rate_ack !== 1'b0)   begin errors++; $display("FAIL rstc_ack: got %b want 0", rate_ack); end
        tick();
        checks++; if (rate_ack !== 1'b0)   begin errors++; $display("FAIL rstc_ack_later: got %b want 0", rate_ack); end
        rate_req = 1'b0; Rst = 1'b0;
    endtask

    task automatic test_enable_off_ratechg();
        int n;
        wait_state(3'd3, 400, n);
        checks++; if (n < 0) begin errors++; $display("FAIL en_lock: got timeout want LOCKED"); end
        rate_div = 8'd100; rate_req = 1'b1;
        tick();
        checks++; if (state_dbg !== 3'd4) begin errors++; $display("FAIL en_ratechg: got %0d want 4", state_dbg); end
        enable = 1'b0;
        tick();
        checks++; if (state_dbg !== 3'd0)  begin errors++; $display("FAIL en_idle: got %0d want 0", state_dbg); end
        checks++; if (rate_ack !== 1'b1)   begin errors++; $display("FAIL en_ack: got %b want 1", rate_ack); end
        checks++; if (pll_en !== 1'b0)     begin errors++; $display("FAIL en_pll_en: got %b want 0", pll_en); end
        checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL en_locked: got %b want 0", pll_locked); end
        checks++; if (tx_clk_en !== 1'b0)  begin errors++; $display("FAIL en_tx_en: got %b want 0", tx_clk_en); end
        checks++; if (div_ratio !== 8'd50) begin errors++; $display("FAIL en_div_kept: got %0d want 50", div_ratio); end
        rate_req = 1'b0;
        tick();
        checks++; if (rate_ack !== 1'b0)   begin errors++; $display("FAIL en_ack_pulse: got %b want 0", rate_ack); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_loss();
        test_rate_change();
        test_rate_zero();
        test_timeout_fail();
        test_rst_in_check();
        test_enable_off_ratechg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
